mu_ram_1rw_port_arb: RTL and testbench
======================================

// Module: mu_ram_1rw_port_arb
// PURPOSE
//  Client-side controller for one mu_ram_1rw single-port RAM (1-cycle read latency).
//  Merges a write stream and a read-request stream onto the RAM's one addr/we port.
//  Returns read data on a back-pressured response stream.
//  Used by thermal-frame buffers: sensor writer on one side, display/scaler reader on the other.
// PARAMETERS
//  DW  8   data width; must equal the attached RAM's DW
//  AW  12  address width; must equal the attached RAM's AW
//  (localparam RSP_DEPTH = 2: response buffer entries; fixed, not overridable)
// PORTS
//  clk            in   1   single clock for the block and the attached RAM
//  rst            in   1   asynchronous, active-high reset
//  wr_valid       in   1   write request present
//  wr_ready       out  1   write accepted this cycle
//  wr_addr        in   AW  write address
//  wr_data        in   DW  write data
//  rd_req_valid   in   1   read request present
//  rd_req_ready   out  1   read request accepted (issued to RAM) this cycle
//  rd_req_addr    in   AW  read address
//  rd_rsp_valid   out  1   read data available
//  rd_rsp_ready   in   1   consumer takes read data
//  rd_rsp_data    out  DW  read data, in request order
//  ram_addr       out  AW  to RAM addr
//  ram_we         out  1   to RAM we
//  ram_wr         out  DW  to RAM wr
//  ram_rd         in   DW  from RAM rd
// BEHAVIOUR
//  - Exactly one RAM op per cycle: write, read, or idle.
//  - credit = (rsp_count + inflight - rsp_pop) < RSP_DEPTH
//      rsp_pop = rd_rsp_valid & rd_rsp_ready.
//  - rd_eligible = rd_req_valid & credit.
//  - Arbitration:
//      only wr_valid -> write; only rd_eligible -> read.
//      both -> grant the side NOT granted last (last_grant reg); last_grant updates on every grant.
//  - wr_ready / rd_req_ready are combinational: each equals its grant for the current cycle.
//      ready may depend on valid; valid must not depend on ready.
//  - RAM drive (combinational):
//      write: ram_we=1, ram_addr=wr_addr, ram_wr=wr_data.
//      read:  ram_we=0, ram_addr=rd_req_addr.
//      idle:  ram_we=0, ram_addr=rd_req_addr, ram_wr=wr_data.
//        Idle causes a spurious RAM read; it is harmless because inflight=0.
//  - inflight register <= (read granted).
//  - When inflight=1, ram_rd is pushed into the response buffer the following cycle.
//    Latency: read grant at cycle N -> rd_rsp_valid no earlier than N+1
//    (N+1 exactly if the buffer was empty).
//  - Response buffer: 2-entry FIFO with first-word output; rd_rsp_data is stable while valid & !ready.
//    Credit guarantees push never hits full; same-cycle push+pop is allowed.
//  - Throughput: back-to-back reads at 1/cycle while rd_rsp_ready=1.
//    Under contention, writes and reads alternate 1:1.
//  - Ordering: ops reach the RAM in grant order.
//    A read granted after a write to the same address returns the new data.
//    A read granted before it returns the old data.
//  - Reset (async assert, sync-to-clk deassert by the top level):
//      inflight=0, buffer empty, last_grant=READ (write wins the first tie);
//      outputs wr_ready=0, rd_req_ready=0, rd_rsp_valid=0, rd_rsp_data=0, ram_we=0 (gated by rst).
//    Mid-operation reset drops any inflight read and flushes buffered responses; no RAM write occurs while rst=1.
//  - No address range checks: AW covers the full RAM depth and addresses wrap naturally.
// STRUCTURE
//  - No package needed beyond the shared mem package; it gains localparam GRANT_WR=1'b0, GRANT_RD=1'b1.
//  - One sub-module: mu_rsp_fifo2 (2-entry FWFT FIFO, DW wide).
//    Ports: push/data_in, pop/data_out, valid, count[1:0], async rst.
//    The arbiter and inflight logic stay in this module.
// TESTING
//  1) Reset: assert rst with wr_valid=rd_req_valid=1
//       -> ram_we=0, all readies=0, rd_rsp_valid=0.
//     Release rst
//       -> first tie grants the write.
//  2) Write then read: write 0x5A @0x010, then read @0x010
//       -> rd_rsp_valid 1 cycle after the read grant, data 0x5A.
//  3) Streaming reads: rd_rsp_ready=1, 8 reads @0x000..0x007 (preloaded i*3)
//       -> 8 grants on consecutive cycles, responses 0,3,...,21 in order.
//  4) Backpressure: rd_rsp_ready=0, 4 read requests
//       -> exactly 2 granted, then rd_req_ready=0.
//     Raise ready
//       -> 2 held responses drain in order, remaining reads proceed; no data lost or duplicated.
//  5) Contention: wr_valid and rd_req_valid held for 10 cycles
//       -> grants alternate W,R,W,R...
//     Read @A after write 0xC3 @A returns 0xC3; read @A before that write returns the old value.
//  6) Mid-op reset: assert rst the cycle after a read grant
//       -> no rd_rsp_valid after release; buffer count 0; the next read returns correct data.

Source files
------------

// File: rtl/mu_ram_pkg.sv
// Shared definitions for the mu_ram_1rw client-side blocks.
// Grant encodings and the per-cycle RAM operation type.
package mu_ram_pkg;

  localparam logic GRANT_WR = 1'b0;
  localparam logic GRANT_RD = 1'b1;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2
  } ram_op_e;

endpackage

// File: rtl/mu_rsp_fifo2.sv
// Two-entry first-word-fall-through response FIFO.
// A push into an empty FIFO is visible on data_out in the same cycle.
module mu_rsp_fifo2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] data_in,
  input  logic          pop,
  output logic [DW-1:0] data_out,
  output logic          valid,
  output logic [1:0]    count
);

  logic [DW-1:0] mem [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic          empty;
  logic          do_pop;
  logic          bypass;

  assign empty  = (count == 2'd0);
  assign valid  = !empty || push;
  assign do_pop = pop && valid;
  // Push and pop of the same word while empty never touches storage.
  assign bypass = empty && push && do_pop;

  always_comb begin
    data_out = '0;
    if (!empty) begin
      data_out = mem[rd_ptr];
    end else if (push) begin
      data_out = data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push && !bypass) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= !wr_ptr;
      end
      if (do_pop && !empty) begin
        rd_ptr <= !rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/mu_ram_1rw_port_arb.sv
// Merges a write stream and a read-request stream onto one single-port RAM
// and returns read data in order on a back-pressured response stream.
module mu_ram_1rw_port_arb
  import mu_ram_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_req_valid,
  output logic          rd_req_ready,
  input  logic [AW-1:0] rd_req_addr,
  output logic          rd_rsp_valid,
  input  logic          rd_rsp_ready,
  output logic [DW-1:0] rd_rsp_data,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wr,
  input  logic [DW-1:0] ram_rd
);

  localparam int RSP_DEPTH = 2;

  logic       inflight;
  logic       last_grant;
  logic       rsp_pop;
  logic       credit;
  logic       rd_eligible;
  logic       grant_wr;
  logic       grant_rd;
  logic [1:0] rsp_count;
  logic [2:0] occupancy;
  ram_op_e    op;

  // A read may issue only if its response is guaranteed a buffer slot.
  assign rsp_pop     = rd_rsp_valid && rd_rsp_ready;
  assign occupancy   = {1'b0, rsp_count} + {2'b00, inflight} - {2'b00, rsp_pop};
  assign credit      = occupancy < 3'(RSP_DEPTH);
  assign rd_eligible = rd_req_valid && credit;

  always_comb begin
    op = OP_IDLE;
    if (!rst) begin
      if (wr_valid && (!rd_eligible || last_grant == GRANT_RD)) begin
        op = OP_WRITE;
      end else if (rd_eligible) begin
        op = OP_READ;
      end
    end
  end

  assign grant_wr     = (op == OP_WRITE);
  assign grant_rd     = (op == OP_READ);
  assign wr_ready     = grant_wr;
  assign rd_req_ready = grant_rd;

  // Idle cycles still present the read address; the data is ignored.
  assign ram_we   = grant_wr;
  assign ram_addr = grant_wr ? wr_addr : rd_req_addr;
  assign ram_wr   = wr_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight   <= 1'b0;
      last_grant <= GRANT_RD;
    end else begin
      inflight <= grant_rd;
      if (grant_wr) begin
        last_grant <= GRANT_WR;
      end else if (grant_rd) begin
        last_grant <= GRANT_RD;
      end
    end
  end

  mu_rsp_fifo2 #(
    .DW(DW)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (inflight),
    .data_in (ram_rd),
    .pop     (rsp_pop),
    .data_out(rd_rsp_data),
    .valid   (rd_rsp_valid),
    .count   (rsp_count)
  );

endmodule

// File: tb/tb_mu_ram_1rw_port_arb.sv
// Directed bench for mu_ram_1rw_port_arb with a behavioural 1-cycle-latency RAM.
module tb_mu_ram_1rw_port_arb;

  localparam int DW = 8;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_req_valid;
  logic          rd_req_ready;
  logic [AW-1:0] rd_req_addr;
  logic          rd_rsp_valid;
  logic          rd_rsp_ready;
  logic [DW-1:0] rd_rsp_data;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wr;
  logic [DW-1:0] ram_rd;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] got [8];
  int            checks_total;
  int            checks_passed;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wr;
    ram_rd <= mem[ram_addr];
  end

  mu_ram_1rw_port_arb #(
    .DW(DW),
    .AW(AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_req_valid(rd_req_valid),
    .rd_req_ready(rd_req_ready),
    .rd_req_addr (rd_req_addr),
    .rd_rsp_valid(rd_rsp_valid),
    .rd_rsp_ready(rd_rsp_ready),
    .rd_rsp_data (rd_rsp_data),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wr      (ram_wr),
    .ram_rd      (ram_rd)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks_total++;
    if (observed === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                               input logic rv, input logic [AW-1:0] ra, input logic rr);
    wr_valid     = wv;
    wr_addr      = wa;
    wr_data      = wd;
    rd_req_valid = rv;
    rd_req_addr  = ra;
    rd_rsp_ready = rr;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic          g;
    logic          wg;
    int            n;
    int            next_rd;
    int            widx;
    int            cyc;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] addr_a;

    checks_total  = 0;
    checks_passed = 0;
    addr_a        = 12'h020;

    // Reset with both requesters active.
    rst = 1'b1;
    applyStimulus(1'b1, 12'h100, 8'h77, 1'b1, 12'h100, 1'b1);
    @(negedge clk);
    checkOutput("reset ram_we", 32'(ram_we), 32'd0);
    checkOutput("reset wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("reset rd_req_ready", 32'(rd_req_ready), 32'd0);
    checkOutput("reset rd_rsp_valid", 32'(rd_rsp_valid), 32'd0);
    checkOutput("reset rd_rsp_data", 32'(rd_rsp_data), 32'd0);
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("first tie wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("first tie rd_req_ready", 32'(rd_req_ready), 32'd0);
    checkOutput("first tie ram_we", 32'(ram_we), 32'd1);
    checkOutput("first tie ram_addr", 32'(ram_addr), 32'h100);
    nextCycle();
    @(negedge clk);
    checkOutput("second tie grants read", {30'd0, wr_ready, rd_req_ready}, 32'b01);
    nextCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("tie read rsp valid", 32'(rd_rsp_valid), 32'd1);
    checkOutput("tie read rsp data", 32'(rd_rsp_data), 32'h77);
    nextCycle();

    // Write then read back the same address.
    applyStimulus(1'b1, 12'h010, 8'h5A, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("wr 0x010 ready", 32'(wr_ready), 32'd1);
    nextCycle();
    applyStimulus(1'b0, '0, '0, 1'b1, 12'h010, 1'b1);
    @(negedge clk);
    checkOutput("rd 0x010 ready", 32'(rd_req_ready), 32'd1);
    checkOutput("rd 0x010 ram_addr", 32'(ram_addr), 32'h010);
    checkOutput("rd 0x010 ram_we", 32'(ram_we), 32'd0);
    nextCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("rd 0x010 rsp valid", 32'(rd_rsp_valid), 32'd1);
    checkOutput("rd 0x010 rsp data", 32'(rd_rsp_data), 32'h5A);
    nextCycle();

    // Preload 0..7 with i*3, then stream eight reads.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, AW'(i), DW'(i * 3), 1'b0, '0, 1'b1);
      @(negedge clk);
      checkOutput("preload wr_ready", 32'(wr_ready), 32'd1);
      nextCycle();
    end
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) applyStimulus(1'b0, '0, '0, 1'b1, AW'(i), 1'b1);
      else       applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
      @(negedge clk);
      if (i < 8) checkOutput("stream grant", 32'(rd_req_ready), 32'd1);
      if (i > 0) begin
        checkOutput("stream rsp valid", 32'(rd_rsp_valid), 32'd1);
        checkOutput("stream rsp data", 32'(rd_rsp_data), 32'((i - 1) * 3));
      end
      nextCycle();
    end

    // Backpressure: only two reads may be outstanding.
    next_rd = 0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, '0, '0, next_rd < 4, AW'(next_rd), 1'b0);
      @(negedge clk);
      checkOutput("bp grant", 32'(rd_req_ready), (c < 2) ? 32'd1 : 32'd0);
      if (c >= 2) begin
        checkOutput("bp held valid", 32'(rd_rsp_valid), 32'd1);
        checkOutput("bp held data", 32'(rd_rsp_data), 32'd0);
      end
      g = rd_req_ready;
      nextCycle();
      if (g) next_rd++;
    end
    n   = 0;
    cyc = 0;
    while (n < 4 && cyc < 20) begin
      applyStimulus(1'b0, '0, '0, next_rd < 4, AW'(next_rd), 1'b1);
      @(negedge clk);
      if (rd_rsp_valid && n < 8) begin
        got[n] = rd_rsp_data;
        n++;
      end
      g = rd_req_ready;
      nextCycle();
      if (g) next_rd++;
      cyc++;
    end
    checkOutput("bp drain count", 32'(n), 32'd4);
    checkOutput("bp reads issued", 32'(next_rd), 32'd4);
    for (int k = 0; k < 4; k++) begin
      checkOutput("bp drain data", 32'(got[k]), 32'(k * 3));
    end
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("bp no duplicate", 32'(rd_rsp_valid), 32'd0);
    nextCycle();

    // Contention: old value 0x11 at A, then alternate writes and reads.
    applyStimulus(1'b1, addr_a, 8'h11, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("ct prep wr", 32'(wr_ready), 32'd1);
    nextCycle();
    applyStimulus(1'b0, '0, '0, 1'b1, addr_a, 1'b1);
    @(negedge clk);
    checkOutput("ct prep rd", 32'(rd_req_ready), 32'd1);
    nextCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("ct prep data", 32'(rd_rsp_data), 32'h11);
    nextCycle();
    widx = 0;
    n    = 0;
    for (int c = 0; c < 11; c++) begin
      if (widx == 1) begin
        wa = addr_a;
        wd = 8'hC3;
      end else begin
        wa = AW'(12'h030 + widx);
        wd = DW'(8'h40 + widx);
      end
      if (c < 10) applyStimulus(1'b1, wa, wd, 1'b1, addr_a, 1'b1);
      else        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
      @(negedge clk);
      if (c < 10) begin
        checkOutput("ct grant", {30'd0, wr_ready, rd_req_ready}, (c % 2 == 0) ? 32'b10 : 32'b01);
      end
      if (rd_rsp_valid && n < 8) begin
        got[n] = rd_rsp_data;
        n++;
      end
      wg = wr_ready;
      nextCycle();
      if (wg) widx++;
    end
    checkOutput("ct rsp count", 32'(n), 32'd5);
    checkOutput("ct read before write", 32'(got[0]), 32'h11);
    for (int k = 1; k < 5; k++) begin
      checkOutput("ct read after write", 32'(got[k]), 32'hC3);
    end

    // Reset the cycle after a read grant; the response must be dropped.
    applyStimulus(1'b1, 12'h050, 8'h9E, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("mr prep wr", 32'(wr_ready), 32'd1);
    nextCycle();
    applyStimulus(1'b0, '0, '0, 1'b1, 12'h050, 1'b0);
    @(negedge clk);
    checkOutput("mr read grant", 32'(rd_req_ready), 32'd1);
    nextCycle();
    rst = 1'b1;
    applyStimulus(1'b1, 12'h050, 8'hEE, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("mr in reset valid", 32'(rd_rsp_valid), 32'd0);
    checkOutput("mr in reset ram_we", 32'(ram_we), 32'd0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("mr after valid", 32'(rd_rsp_valid), 32'd0);
    checkOutput("mr after count", 32'(dut.u_rsp_fifo.count), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("mr later valid", 32'(rd_rsp_valid), 32'd0);
    nextCycle();
    applyStimulus(1'b0, '0, '0, 1'b1, 12'h050, 1'b1);
    @(negedge clk);
    checkOutput("mr next read grant", 32'(rd_req_ready), 32'd1);
    nextCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("mr next read valid", 32'(rd_rsp_valid), 32'd1);
    checkOutput("mr next read data", 32'(rd_rsp_data), 32'h9E);
    nextCycle();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
